// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and default constants for the input debouncer.
//               Holds the debounce FSM state encoding and the default
//               synchronizer depth / stability window.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Default number of synchronizer flops on the raw input.
    localparam int C_SYNC_STAGES   = 2;
    // Default number of consecutive identical samples to accept a new level.
    localparam int C_STABLE_CYCLES = 4;

    // Debounce FSM states: two stable states and two qualification states.
    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } deb_state_t;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Parameterized N-stage flop synchronizer for a single-bit
//               asynchronous input. All stages reset to RST_VAL.
// Parameters  : DEPTH   - number of flop stages (>= 2)
//               RST_VAL - value loaded into every stage during reset
// Ports       : clk  in  1  sampling clock (rising edge)
//               rstn in  1  asynchronous active-low reset
//               d_i  in  1  raw asynchronous input
//               q_o  out 1  synchronized output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    if (DEPTH < 2) begin : g_depth_check
        $error("sync_ff: DEPTH must be at least 2");
    end

    logic [DEPTH-1:0] sync_q;

    // Bit 0 is the metastability-exposed capture flop; higher bits settle it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronizes a raw asynchronous level and debounces it into a
//               clean registered level with single-cycle rise/fall strobes.
//               A new level is accepted only after STABLE_CYCLES consecutive
//               identical synchronized samples while en is high.
// Build macro : INPUT_DEBOUNCER_GLITCH_CNT_EN - adds glitch_clr/glitch_cnt and
//               a saturating counter of rejected transitions.
// Parameters  : SYNC_STAGES (>=2), STABLE_CYCLES (>=2), INIT_LEVEL, GLITCH_W
// Ports       : clk        in  1         rising-edge clock
//               rstn       in  1         asynchronous active-low reset
//               din        in  1         raw asynchronous input
//               en         in  1         debounce enable (low freezes level)
//               level      out 1         debounced level (registered)
//               rise       out 1         one-cycle strobe on level 0->1
//               fall       out 1         one-cycle strobe on level 1->0
//               busy       out 1         candidate transition being qualified
//               glitch_clr in  1         sync clear of glitch_cnt (macro only)
//               glitch_cnt out GLITCH_W  saturating glitch count (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = C_SYNC_STAGES,
    parameter int   STABLE_CYCLES = C_STABLE_CYCLES,
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                din,
    input  logic                en,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic                busy
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    ,
    input  logic                glitch_clr,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int                 CNT_W       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);
    localparam deb_state_t         C_RST_STATE = INIT_LEVEL ? HI : LO;

    if (STABLE_CYCLES < 2) begin : g_stable_check
        $error("input_debouncer: STABLE_CYCLES must be at least 2");
    end

    if (GLITCH_W < 1) begin : g_glitch_w_check
        $error("input_debouncer: GLITCH_W must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------------
    logic din_s;

    sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (INIT_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (din),
        .q_o  (din_s)
    );

    // ------------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------------
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             glitch_evt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= C_RST_STATE;
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Within a WAIT state the checks are ordered: enable abort first (no
    // glitch), then reversion (glitch, and it beats a same-edge completion),
    // then completion, then keep counting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_evt = 1'b0;

        unique case (state_q)
            LO: begin
                if (en && din_s) begin
                    state_d = WAIT_HI;
                    cnt_d   = C_CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!en) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else if (!din_s) begin
                    state_d    = LO;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            HI: begin
                if (en && !din_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = C_CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (!en) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else if (din_s) begin
                    state_d    = HI;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = C_RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    // Derived from the state register only, so still glitch-free.
    assign busy  = (state_q == WAIT_HI) || (state_q == WAIT_LO);

    // ------------------------------------------------------------------------
    // Optional glitch counter
    // ------------------------------------------------------------------------
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt_q;

    // Clear has priority over a same-cycle increment; count saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glitch_cnt_q <= '0;
        end else if (glitch_clr) begin
            glitch_cnt_q <= '0;
        end else if (glitch_evt && (glitch_cnt_q != {GLITCH_W{1'b1}})) begin
            glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_glitch_evt;
    assign unused_glitch_evt = glitch_evt;
`endif

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Self-checking bench for input_debouncer. A behavioural model
//               tracks the synchronized input as a delayed copy of din and
//               counts the run of consecutive enabled samples that differ from
//               the accepted level; a run reaching STABLE_CYCLES flips the
//               level, a run broken by the old level is a glitch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int SYNC   = 2;
    localparam int STAB   = 4;
    localparam int GW     = 8;
    localparam int GMAX   = (1 << GW) - 1;

    logic clk;
    logic rstn;
    logic din;
    logic en;
    logic glitch_clr;
    logic level, rise, fall, busy;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB),
        .INIT_LEVEL    (1'b0),
        .GLITCH_W      (GW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .en         (en),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [SYNC-1:0] m_hist;
    int              m_run;
    logic            m_level, m_rise, m_fall, m_busy;
    int              m_glitch;

    assign m_busy = (m_run != 0);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_hist   <= '0;
            m_run    <= 0;
            m_level  <= 1'b0;
            m_rise   <= 1'b0;
            m_fall   <= 1'b0;
            m_glitch <= 0;
        end else begin : model_step
            logic ds;
            logic g;
            ds = m_hist[SYNC-1];
            g  = 1'b0;
            m_hist <= {m_hist[SYNC-2:0], din};
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (!en) begin
                m_run <= 0;
            end else if (ds != m_level) begin
                if (m_run + 1 == STAB) begin
                    m_level <= ds;
                    m_rise  <= ds;
                    m_fall  <= ~ds;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                g = (m_run > 0);
                m_run <= 0;
            end
            if (glitch_clr)
                m_glitch <= 0;
            else if (g && m_glitch < GMAX)
                m_glitch <= m_glitch + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Scenarios (checks at negedge, inputs driven right after)
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; din = 1'b0; en = 1'b1; glitch_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got l/r/f/b=%b required 0000", {level, rise, fall, busy});
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_glitch_cnt: got %0d required 0", glitch_cnt);
        end
`endif
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, busy} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_release_idle: got l/r/f/b=%b required 0000", {level, rise, fall, busy});
            end
        end
    endtask

    task automatic test_rise();
        din = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_fail++;
                $display("FAIL rise_seq cyc%0d: got l/r/f/b=%b required %b", k,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
            if (k == 5) begin
                n_checks++;
                if ({level, busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL rise_before_6th: got level/busy=%b required 01", {level, busy});
                end
            end
            if (k == 6) begin
                n_checks++;
                if ({level, rise, fall} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL rise_at_6th: got l/r/f=%b required 110", {level, rise, fall});
                end
            end
            if (k == 7) begin
                n_checks++;
                if ({level, rise} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL rise_one_cycle: got level/rise=%b required 10", {level, rise});
                end
            end
        end
    endtask

    task automatic test_fall();
        din = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_fail++;
                $display("FAIL fall_seq cyc%0d: got l/r/f/b=%b required %b", k,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
            if (k == 6) begin
                n_checks++;
                if ({level, rise, fall} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL fall_at_6th: got l/r/f=%b required 001", {level, rise, fall});
                end
            end
        end
    endtask

    task automatic test_glitch();
        int g0;
        logic saw_rise;
        g0 = m_glitch;
        saw_rise = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            din = (k <= 2);
            @(negedge clk);
            saw_rise |= rise;
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_fail++;
                $display("FAIL glitch_seq cyc%0d: got l/r/f/b=%b required %b", k,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if ({saw_rise, level} !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch_rejected: got rise_seen/level=%b required 00", {saw_rise, level});
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_checks++;
        if (int'(glitch_cnt) !== g0 + 1) begin
            n_fail++;
            $display("FAIL glitch_counted: got %0d required %0d", glitch_cnt, g0 + 1);
        end
`endif
    endtask

    task automatic test_enable();
        int g0;
        g0 = m_glitch;
        din = 1'b1;
        en  = 1'b1;
        // Reach qualification cycle 2, then drop enable.
        repeat (4) @(negedge clk);
        en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, busy} !== 4'b0000) begin
                n_fail++;
                $display("FAIL enable_abort cyc%0d: got l/r/f/b=%b required 0000", k, {level, rise, fall, busy});
            end
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        n_checks++;
        if (int'(glitch_cnt) !== g0) begin
            n_fail++;
            $display("FAIL enable_no_glitch: got %0d required %0d", glitch_cnt, g0);
        end
`endif
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (level !== (k >= 4) || rise !== (k == 4)) begin
                n_fail++;
                $display("FAIL enable_requal cyc%0d: got level/rise=%b%b required %b%b", k, level, rise,
                         (k >= 4), (k == 4));
            end
        end
        // Return to low level for the next scenario.
        din = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_async_reset();
        din = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_in_wait: got busy=%b required 1", busy);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_immediate: got l/r/f/b=%b required 0000", {level, rise, fall, busy});
        end
        din = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, busy} !== 4'b0000) begin
                n_fail++;
                $display("FAIL areset_release cyc%0d: got l/r/f/b=%b required 0000", k, {level, rise, fall, busy});
            end
        end
    endtask

    task automatic test_saturate();
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        // Alternating 1/0 samples give one glitch every two cycles.
        for (int k = 0; k < 600; k++) begin
            din = k[0] ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (int'(glitch_cnt) !== GMAX || m_glitch !== GMAX) begin
            n_fail++;
            $display("FAIL glitch_saturate: got %0d required %0d", glitch_cnt, GMAX);
        end
        // Two cleared edges: one WAIT entry, one glitch abort.
        glitch_clr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din = k[0] ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (glitch_cnt !== '0) begin
            n_fail++;
            $display("FAIL glitch_clr_wins: got %0d required 0", glitch_cnt);
        end
        glitch_clr = 1'b0;
        din = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (int'(glitch_cnt) !== m_glitch) begin
                n_fail++;
                $display("FAIL glitch_after_clr cyc%0d: got %0d required %0d", k, glitch_cnt, m_glitch);
            end
        end
`endif
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int k = 1; k <= 1500; k++) begin
            if (hold == 0) begin
                din  = $urandom_range(0, 1);
                hold = $urandom_range(1, 7);
            end
            hold--;
            en         = ($urandom_range(0, 15) != 0);
            glitch_clr = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got l/r/f/b=%b required %b", k,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
            n_checks++;
            if (int'(glitch_cnt) !== m_glitch) begin
                n_fail++;
                $display("FAIL random_glitch cyc%0d: got %0d required %0d", k, glitch_cnt, m_glitch);
            end
`endif
        end
        glitch_clr = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_enable();
        test_async_reset();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_input_debouncer
`default_nettype wire
